// File: rtl/axi4_pin_check_master.sv
// rtl/axi4_pin_check_master.sv - AXI4-Lite master that submits a PIN, polls the checker and streams out the flag
module axi4_pin_check_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          POLL_GAP  = 16,
  parameter int          MAX_POLLS = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pin_valid,
  output logic        pin_ready,
  input  logic [7:0]  pin_data,
  output logic        flag_valid,
  input  logic        flag_ready,
  output logic [7:0]  flag_data,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_wvalid,
  input  logic        m_wready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata
);

  localparam logic [3:0] S_COLLECT  = 4'd0;
  localparam logic [3:0] S_WR_PIN   = 4'd1;
  localparam logic [3:0] S_WR_START = 4'd2;
  localparam logic [3:0] S_GAP      = 4'd3;
  localparam logic [3:0] S_POLL     = 4'd4;
  localparam logic [3:0] S_STATUS   = 4'd5;
  localparam logic [3:0] S_FLAG_RD  = 4'd6;
  localparam logic [3:0] S_FLAG_OUT = 4'd7;
  localparam logic [3:0] S_FIN      = 4'd8;

  localparam logic [7:0] GAP_LAST  = 8'(POLL_GAP - 1);
  localparam logic [7:0] POLL_LIMIT = 8'(MAX_POLLS);

  logic [3:0]  state;
  logic        busy;
  logic [3:0]  bidx;
  logic [1:0]  widx;
  logic [7:0]  poll_cnt;
  logic [7:0]  gap_cnt;
  logic [7:0]  data_buf [16];
  logic [31:0] cur_word;
  logic [31:0] rd_off;
  logic        b_hs;
  logic        r_hs;

  assign m_awprot   = 3'b000;
  assign m_arprot   = 3'b000;
  assign m_wstrb    = 4'hf;
  assign pin_ready  = resetn && (state == S_COLLECT);
  assign flag_valid = (state == S_FLAG_OUT);
  assign flag_data  = data_buf[bidx];
  assign done       = (state == S_FIN);
  assign b_hs       = m_bvalid && m_bready;
  assign r_hs       = m_rvalid && m_rready;

  always_comb begin
    cur_word = {data_buf[{widx, 2'b11}], data_buf[{widx, 2'b10}],
                data_buf[{widx, 2'b01}], data_buf[{widx, 2'b00}]};
    rd_off = 32'h14;
    if (state == S_STATUS)  rd_off = 32'h18;
    if (state == S_FLAG_RD) rd_off = 32'h20 + {28'd0, widx, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= S_COLLECT;
      busy      <= 1'b0;
      bidx      <= 4'd0;
      widx      <= 2'd0;
      poll_cnt  <= 8'd0;
      gap_cnt   <= 8'd0;
      pass      <= 1'b0;
      timeout   <= 1'b0;
      m_awvalid <= 1'b0;
      m_awaddr  <= 32'd0;
      m_wvalid  <= 1'b0;
      m_wdata   <= 32'd0;
      m_bready  <= 1'b0;
      m_arvalid <= 1'b0;
      m_araddr  <= 32'd0;
      m_rready  <= 1'b0;
    end else begin
      // AW and W retire independently; the write only completes on B
      if (m_awvalid && m_awready) m_awvalid <= 1'b0;
      if (m_wvalid && m_wready)   m_wvalid  <= 1'b0;
      if (m_arvalid && m_arready) m_arvalid <= 1'b0;

      case (state)
        S_COLLECT: begin
          if (pin_valid) begin
            data_buf[bidx] <= pin_data;
            bidx <= bidx + 4'd1;
            if (bidx == 4'd0) begin
              pass    <= 1'b0;
              timeout <= 1'b0;
            end
            if (bidx == 4'd15) begin
              state <= S_WR_PIN;
              widx  <= 2'd0;
            end
          end
        end

        S_WR_PIN, S_WR_START: begin
          if (!busy) begin
            busy      <= 1'b1;
            m_awvalid <= 1'b1;
            m_wvalid  <= 1'b1;
            m_bready  <= 1'b1;
            m_awaddr  <= BASE_ADDR + ((state == S_WR_PIN) ? {28'd0, widx, 2'b00} : 32'h10);
            m_wdata   <= (state == S_WR_PIN) ? cur_word : 32'd0;
          end else if (b_hs) begin
            busy     <= 1'b0;
            m_bready <= 1'b0;
            if (state == S_WR_START) begin
              poll_cnt <= 8'd0;
              gap_cnt  <= 8'd0;
              state    <= S_GAP;
            end else if (widx == 2'd3) begin
              state <= S_WR_START;
            end else begin
              widx <= widx + 2'd1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= 8'd0;
            state   <= S_POLL;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        S_POLL, S_STATUS, S_FLAG_RD: begin
          if (!busy) begin
            busy      <= 1'b1;
            m_arvalid <= 1'b1;
            m_rready  <= 1'b1;
            m_araddr  <= BASE_ADDR + rd_off;
          end else if (r_hs) begin
            busy     <= 1'b0;
            m_rready <= 1'b0;
            if (state == S_POLL) begin
              if (m_rdata[0]) begin
                poll_cnt <= poll_cnt + 8'd1;
                gap_cnt  <= 8'd0;
                if (poll_cnt + 8'd1 == POLL_LIMIT) begin
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  state   <= S_FIN;
                end else begin
                  state <= S_GAP;
                end
              end else begin
                state <= S_STATUS;
              end
            end else if (state == S_STATUS) begin
              pass <= m_rdata[0];
              widx <= 2'd0;
              state <= m_rdata[0] ? S_FLAG_RD : S_FIN;
            end else begin
              data_buf[{widx, 2'b00}] <= m_rdata[7:0];
              data_buf[{widx, 2'b01}] <= m_rdata[15:8];
              data_buf[{widx, 2'b10}] <= m_rdata[23:16];
              data_buf[{widx, 2'b11}] <= m_rdata[31:24];
              if (widx == 2'd3) begin
                bidx  <= 4'd0;
                state <= S_FLAG_OUT;
              end else begin
                widx <= widx + 2'd1;
              end
            end
          end
        end

        S_FLAG_OUT: begin
          if (flag_ready) begin
            bidx <= bidx + 4'd1;
            if (bidx == 4'd15) state <= S_FIN;
          end
        end

        S_FIN: begin
          bidx  <= 4'd0;
          state <= S_COLLECT;
        end

        default: state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_pin_check_master.sv
// tb/tb_axi4_pin_check_master.sv - directed bench for axi4_pin_check_master with a small AXI-Lite PIN device model
module tb_axi4_pin_check_master;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        pin_valid = 1'b0;
  logic        pin_ready;
  logic [7:0]  pin_data = 8'd0;
  logic        flag_valid;
  logic        flag_ready = 1'b1;
  logic [7:0]  flag_data;
  logic        done, pass, timeout;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [2:0]  m_awprot;
  logic        m_wvalid, m_wready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [2:0]  m_arprot;
  logic        m_rvalid, m_rready;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  axi4_pin_check_master #(.BASE_ADDR(32'h0), .POLL_GAP(2), .MAX_POLLS(3)) dut (
    .clk(clk), .resetn(resetn),
    .pin_valid(pin_valid), .pin_ready(pin_ready), .pin_data(pin_data),
    .flag_valid(flag_valid), .flag_ready(flag_ready), .flag_data(flag_data),
    .done(done), .pass(pass), .timeout(timeout),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awprot(m_awprot),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arprot(m_arprot),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata)
  );

  int n_chk = 0;
  int n_fail = 0;

  // scenario knobs, written only by the stimulus process
  logic clr = 1'b0;
  int   aw_hold_cfg = 0;
  int   busy_cfg = 0;
  bit   fr_mode = 1'b0;

  // device model state
  logic        got_aw, got_w, bvalid_r, rvalid_r;
  logic [31:0] aw_a, w_d, aw_last, rdata_r;
  logic [31:0] pin_reg [4];
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  int          aw_stall, wr_n, poll_n, frd_n, perr;

  assign m_awready = (aw_stall >= aw_hold_cfg);
  assign m_wready  = 1'b1;
  assign m_arready = 1'b1;
  assign m_bvalid  = bvalid_r;
  assign m_rvalid  = rvalid_r;
  assign m_rdata   = rdata_r;

  always @(posedge clk) begin
    int e;
    e = 0;
    if (!resetn || clr) begin
      got_aw <= 1'b0; got_w <= 1'b0; bvalid_r <= 1'b0; rvalid_r <= 1'b0;
      rdata_r <= 32'd0; aw_stall <= 0; wr_n <= 0; poll_n <= 0; frd_n <= 0; perr <= 0;
      aw_last <= 32'd0;
      for (int i = 0; i < 4; i++) pin_reg[i] <= 32'd0;
    end else begin
      if (got_aw && got_w && !bvalid_r) begin
        if (wr_n < 8) begin
          wr_addr[wr_n] <= aw_a;
          wr_data[wr_n] <= w_d;
        end
        if (aw_a < 32'h10) pin_reg[aw_a[3:2]] <= w_d;
        wr_n <= wr_n + 1;
        bvalid_r <= 1'b1;
        got_aw <= 1'b0;
        got_w <= 1'b0;
      end
      if (m_awvalid && !m_awready) aw_stall <= aw_stall + 1;
      if (m_awvalid && aw_stall != 0 && m_awaddr != aw_last) e++;
      aw_last <= m_awaddr;
      if (m_awvalid && m_awready) begin
        aw_stall <= 0;
        got_aw <= 1'b1;
        aw_a <= m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        if (got_w) e++;
        got_w <= 1'b1;
        w_d <= m_wdata;
      end
      if (m_awprot != 3'b000 || m_arprot != 3'b000 || m_wstrb != 4'hf) e++;
      if (m_arvalid && (m_awvalid || m_wvalid || got_aw || got_w || bvalid_r || rvalid_r)) e++;
      if (bvalid_r && m_bready) bvalid_r <= 1'b0;
      if (m_arvalid && m_arready) begin
        rvalid_r <= 1'b1;
        case (m_araddr)
          32'h14: begin
            rdata_r <= (poll_n < busy_cfg) ? 32'd1 : 32'd0;
            poll_n <= poll_n + 1;
          end
          32'h18: rdata_r <= (pin_reg[0] == 32'h00bbaaff && pin_reg[1] == 0 &&
                              pin_reg[2] == 0 && pin_reg[3] == 0) ? 32'd1 : 32'd0;
          32'h20: begin rdata_r <= 32'h4F434553; frd_n <= frd_n + 1; end
          32'h24: begin rdata_r <= 32'h465F444E; frd_n <= frd_n + 1; end
          32'h28: begin rdata_r <= 32'h3047414C; frd_n <= frd_n + 1; end
          32'h2c: begin rdata_r <= 32'h30303030; frd_n <= frd_n + 1; end
          default: rdata_r <= 32'd0;
        endcase
      end
      if (rvalid_r && m_rready) rvalid_r <= 1'b0;
      perr <= perr + e;
    end
  end

  // flag sink and done counter, sampled on the falling edge
  logic [7:0] fl [16];
  int         fl_n, done_n, stall_err;
  logic       have_stall = 1'b0;
  logic       fr_t = 1'b0;
  logic [7:0] stall_data;

  always @(negedge clk) begin
    if (clr || !resetn) begin
      fl_n = 0; done_n = 0; stall_err = 0; have_stall = 1'b0;
    end else begin
      if (have_stall && (!flag_valid || flag_data != stall_data)) stall_err++;
      fr_t = ~fr_t;
      flag_ready = fr_mode ? fr_t : 1'b1;
      if (done) done_n++;
      have_stall = flag_valid && !flag_ready;
      stall_data = flag_data;
      if (flag_valid && flag_ready) begin
        if (fl_n < 16) fl[fl_n] = flag_data;
        fl_n++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  b0;
    int          aw_hold;
    int          busy;
    bit          frm;
    bit          e_pass;
    bit          e_to;
    int          e_flags;
    int          e_polls;
    int          e_frd;
    logic [31:0] e_w0;
  } vec_t;

  vec_t vt [5];
  logic pass_first, to_first;

  task automatic send_pin(input logic [7:0] b0);
    for (int i = 0; i < 16; i++) begin
      int c;
      @(negedge clk);
      if (i == 1) begin
        pass_first = pass;
        to_first = timeout;
      end
      pin_valid = 1'b1;
      pin_data = (i == 0) ? b0 : (i == 1) ? 8'haa : (i == 2) ? 8'hbb : 8'h00;
      c = 0;
      while (!pin_ready && c < 100) begin
        @(negedge clk);
        c++;
      end
      if (c == 100) chk("pin_ready_wait", 32'd0, 32'd1);
    end
    @(negedge clk);
    pin_valid = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic run_vec(input int k);
    bit   got;
    string fs;
    fs = "SECOND_FLAG00000";
    aw_hold_cfg = vt[k].aw_hold;
    busy_cfg = vt[k].busy;
    fr_mode = vt[k].frm;
    pulse_clr();
    send_pin(vt[k].b0);
    chk($sformatf("v%0d_pass_cleared", k), {31'd0, pass_first}, 32'd0);
    chk($sformatf("v%0d_timeout_cleared", k), {31'd0, to_first}, 32'd0);
    got = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_done_seen", k), {31'd0, got}, 32'd1);
    repeat (4) @(negedge clk);
    chk($sformatf("v%0d_done_count", k), done_n, 32'd1);
    chk($sformatf("v%0d_pass", k), {31'd0, pass}, {31'd0, vt[k].e_pass});
    chk($sformatf("v%0d_timeout", k), {31'd0, timeout}, {31'd0, vt[k].e_to});
    chk($sformatf("v%0d_status_polls", k), poll_n, vt[k].e_polls);
    chk($sformatf("v%0d_flag_reads", k), frd_n, vt[k].e_frd);
    chk($sformatf("v%0d_flag_bytes", k), fl_n, vt[k].e_flags);
    chk($sformatf("v%0d_stall_stable", k), stall_err, 32'd0);
    chk($sformatf("v%0d_protocol", k), perr, 32'd0);
    chk($sformatf("v%0d_write_count", k), wr_n, 32'd5);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("v%0d_waddr%0d", k, i), wr_addr[i], 32'(i * 4));
      chk($sformatf("v%0d_wdata%0d", k, i), wr_data[i], (i == 0) ? vt[k].e_w0 : 32'd0);
    end
    if (vt[k].e_flags == 16) begin
      for (int i = 0; i < 16; i++)
        chk($sformatf("v%0d_flag%0d", k, i), {24'd0, fl[i]}, {24'd0, fs[i]});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    vt[0] = '{8'hff, 0, 1,   1'b0, 1'b1, 1'b0, 16, 2, 4, 32'h00bbaaff};
    vt[1] = '{8'hfe, 0, 0,   1'b0, 1'b0, 1'b0, 0,  1, 0, 32'h00bbaafe};
    vt[2] = '{8'hff, 5, 0,   1'b0, 1'b1, 1'b0, 16, 1, 4, 32'h00bbaaff};
    vt[3] = '{8'hff, 0, 255, 1'b0, 1'b0, 1'b1, 0,  3, 0, 32'h00bbaaff};
    vt[4] = '{8'hff, 0, 2,   1'b1, 1'b1, 1'b0, 16, 3, 4, 32'h00bbaaff};

    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {22'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, pin_ready,
         flag_valid, done, pass, timeout}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("collect_after_reset", {31'd0, pin_ready}, 32'd1);

    for (int k = 0; k < 5; k++) run_vec(k);

    // reset asserted while the flag words are being read back
    aw_hold_cfg = 0;
    busy_cfg = 0;
    fr_mode = 1'b0;
    pulse_clr();
    send_pin(8'hff);
    chk("rst_pass_cleared", {31'd0, pass_first}, 32'd0);
    found = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (m_arvalid && m_araddr == 32'h24) begin
        found = 1'b1;
        break;
      end
    end
    chk("rst_reached_flag_rd", {31'd0, found}, 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_valids_low",
        {25'd0, m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready, flag_valid, done}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_back_to_collect", {30'd0, pin_ready, pass}, 32'd2);
    repeat (3) @(negedge clk);
    chk("rst_stays_idle", {29'd0, m_arvalid, m_awvalid, flag_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
